serial_add_ctrl: RTL and testbench

Bit-serial addition controller that shares one `full_adder` cell across all bit positions of a WIDTH-bit operand pair. Operands are accepted over a valid/ready handshake and presented LSB-first to the adder, one bit per clock, with the carry registered between cycles. The result is returned over a second valid/ready handshake. The block is the low-area alternative to a ripple array in the arithmetic datapath.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_full_adder.sv | 14 +
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The optional subtract path is enabled by defining SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so WIDTH-1 always fits, including WIDTH=1.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell shared across all bit positions
// by the bit-serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full_adder, LSB first, carry registered.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via ~b and carry-in of 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             carry_load;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the caller's cin is overridden.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The new sum bit enters at the MSB so the LSB lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_sum;
    end else begin : g_sum_wn
      assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum_q <= sum_shift;
      carry <= fa_carry;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        cout_q <= fa_carry;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1
// against an arithmetic model; sub tests run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, cout1, busy1;
  logic [0:0] sum1;

  logic [8:0] mdl8 = '0;
  logic [1:0] mdl1 = '0;
  int         asserts = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  function automatic logic [8:0] model8(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic ic, input logic is);
    if (SUB_EN && is) return {1'b0, ia} + {1'b0, ~ib} + 9'd1;
    return {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison: exactly one of IDLE/RUN/DONE, result matches model when visible.
  always @(negedge clk) begin
    check("cmp8 state onehot", 64'($onehot({in_ready8, busy8, out_valid8})), 64'd1);
    check("cmp1 state onehot", 64'($onehot({in_ready1, busy1, out_valid1})), 64'd1);
    if (in_ready8 || out_valid8) check("cmp8 result", {cout8, sum8}, mdl8);
    if (in_ready1 || out_valid1) check("cmp1 result", {cout1, sum1}, mdl1);
  end

  // Runs one WIDTH=8 operation; entered and left at #1 after a rising edge.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                               input logic is, input int hold, input bit pulse);
    int lat;
    check("w8 in_ready before accept", in_ready8, 1);
    a8 = ia; b8 = ib; cin8 = ic; sub8 = is; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    mdl8 = model8(ia, ib, ic, is);
    a8 = ~ia; b8 = ~ib; cin8 = ~ic;
    lat = 0;
    while (!out_valid8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8 latency", 64'(lat), 64'd8);
    if (out_valid8) begin
      for (int i = 0; i < hold; i++) begin
        in_valid8 = pulse && (i % 2 == 0);
        a8 = 8'hA5; b8 = 8'h5A;
        check("hold out_valid", out_valid8, 1);
        check("hold in_ready", in_ready8, 0);
        check("hold result stable", {cout8, sum8}, mdl8);
        @(posedge clk); #1;
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("w8 release in_ready", in_ready8, 1);
      check("w8 release out_valid", out_valid8, 0);
    end
  endtask

  task automatic applyStimulusW1(input logic ia, input logic ib, input logic ic);
    int lat;
    check("w1 in_ready before accept", in_ready1, 1);
    a1 = ia; b1 = ib; cin1 = ic; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    mdl1 = 2'(ia) + 2'(ib) + 2'(ic);
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1 latency", 64'(lat), 64'd1);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("w1 result", {cout1, sum1}, mdl1);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_sum, input logic exp_cout);
    check({name, " sum"}, sum8, exp_sum);
    check({name, " cout"}, cout8, exp_cout);
    check({name, " model pin"}, mdl8, {exp_cout, exp_sum});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready8, 1);
    check("reset out_valid", out_valid8, 0);
    check("reset busy", busy8, 0);
    check("reset sum", sum8, 0);
    check("reset cout", cout8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("0F+01", 8'h10, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("FF+01", 8'h00, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("FF+FF+1", 8'hFF, 1'b1);

    applyStimulus(8'h3C, 8'h5A, 1'b1, 1'b0, 5, 1'b1);
    checkOutput("backpressure", 8'h97, 1'b0);
    @(posedge clk); #1;
    check("no overlap busy", busy8, 0);
    check("no overlap in_ready", in_ready8, 1);

    // Abort an operation partway through RUN.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    mdl8 = model8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre-abort busy", busy8, 1);
    rst = 1'b1;
    mdl8 = '0;
    #1;
    check("abort in_ready", in_ready8, 1);
    check("abort out_valid", out_valid8, 0);
    check("abort busy", busy8, 0);
    check("abort sum", sum8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("after abort", 8'h46, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, 1'b0, 0, 1'b0);
      check("random result", {cout8, sum8}, model8(ra, rb, rc, 1'b0));
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulusW1(i[2], i[1], i[0]);
    end
    check("w1 pin 1+1+1", {cout1, sum1}, 2'b11);

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("07-05", 8'h02, 1'b1);
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("05-07", 8'hFE, 1'b0);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
